// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  // pc + instr + exc_en + exc_code + exc_val
  localparam int unsigned FETCH_ENTRY_W = 64 + 32 + 1 + 4 + 64;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StExcHold = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  // Head contents presented while the buffer has never been written.
  function automatic fetch_entry_t reset_entry();
    fetch_entry_t e;
    e.pc       = 64'h0;
    e.instr    = NOP_INSTR;
    e.exc_en   = 1'b0;
    e.exc_code = 4'h0;
    e.exc_val  = 64'h0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch FIFO. The head register drives the stage outputs directly
// and keeps its last value when the FIFO drains or is flushed.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [FETCH_ENTRY_W-1:0] push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [FETCH_ENTRY_W-1:0] head
);

  logic [FETCH_ENTRY_W-1:0] head_q, head_d;
  logic [FETCH_ENTRY_W-1:0] tail_q, tail_d;
  logic [1:0]               count_q, count_d;
  logic                     pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);
  assign full   = (count_q == 2'd2);
  assign empty  = (count_q == 2'd0);
  assign head   = head_q;

  // Next-state for head/tail data and occupancy; flush wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = push_data;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            tail_d  = push_data;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_data;
          end else begin
            head_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= reset_entry();
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV64 instruction fetch stage: PC register, RUN/EXC_HOLD control and
// entry formation from a zero-wait instruction memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  fetch_state_e             state_q, state_d;
  logic [63:0]              pc_q, pc_d;
  fetch_entry_t             push_entry;
  fetch_entry_t             head_entry;
  logic [FETCH_ENTRY_W-1:0] head_raw;
  logic                     buf_full, buf_empty;
  logic                     pop, fetch_fire;

  assign imem_addr  = pc_q;
  assign out_valid  = !buf_empty;
  assign pop        = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full buffer still streams.
  assign fetch_fire = (state_q == StRun) && !redirect_en && (!buf_full || pop);

  // Entry formation: misalignment masks the memory response entirely.
  always_comb begin
    push_entry.pc       = pc_q;
    push_entry.instr    = imem_instr;
    push_entry.exc_en   = 1'b0;
    push_entry.exc_code = 4'h0;
    push_entry.exc_val  = 64'h0;
    if (pc_q[1:0] != 2'b00) begin
      push_entry.instr    = NOP_INSTR;
      push_entry.exc_en   = 1'b1;
      push_entry.exc_code = EXC_INSTR_MISALIGNED;
      push_entry.exc_val  = pc_q;
    end else if (imem_exc_en) begin
      push_entry.instr    = NOP_INSTR;
      push_entry.exc_en   = 1'b1;
      push_entry.exc_code = imem_exc_code;
      push_entry.exc_val  = imem_exc_val;
    end
  end

  // PC and state next-state: redirect first, then advance or hold on exception.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = StRun;
    end else if (fetch_fire) begin
      if (push_entry.exc_en) begin
        state_d = StExcHold;
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  // PC and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (fetch_fire),
    .push_data (push_entry),
    .pop       (pop),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head_raw)
  );

  assign head_entry   = fetch_entry_t'(head_raw);
  assign out_pc       = head_entry.pc;
  assign out_instr    = head_entry.instr;
  assign out_exc_en   = head_entry.exc_en;
  assign out_exc_code = head_entry.exc_code;
  assign out_exc_val  = head_entry.exc_val;

endmodule
